// File: rtl/seq_mult_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_ctrl_pkg
// Purpose  : Shared constants and state encoding for the sequential multiplier.
// Revision : 1.0
// ============================================================================
package seq_mult_ctrl_pkg;

   localparam int MUL_ITER = 32;
   localparam int ADDER_W  = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mult_state_t;

endpackage : seq_mult_ctrl_pkg
`default_nettype wire

// File: rtl/yAdder32.sv
`default_nettype none
// ============================================================================
// Module   : yAdder32
// Purpose  : 32-bit ripple-carry adder with carry-in and carry-out.
// Revision : 1.0
// ============================================================================
module yAdder32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] z,
   output logic        cout
);

   logic [32:0] w_carry;

   assign w_carry[0] = cin;

   for (genvar i = 0; i < 32; i++) begin : g_bit
      logic w_p;
      assign w_p            = a[i] ^ b[i];
      assign z[i]           = w_p ^ w_carry[i];
      assign w_carry[i + 1] = (a[i] & b[i]) | (w_p & w_carry[i]);
   end

   assign cout = w_carry[32];

endmodule : yAdder32
`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_ctrl
// Purpose  : 32x32 unsigned shift-add multiplier sequencing one yAdder32.
// Revision : 1.0
// ============================================================================
module seq_mult_ctrl
   import seq_mult_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo
);

   localparam logic [CNT_W-1:0] c_last = CNT_W'(MUL_ITER - 1);

   if (WIDTH != ADDER_W) begin : g_bad_width
      $error("seq_mult_ctrl: WIDTH must equal the adder width");
   end
   if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt
      $error("seq_mult_ctrl: CNT_W too narrow for WIDTH iterations");
   end

   mult_state_t      r_state, w_state_nxt;
   logic [WIDTH-1:0] r_m,  w_m_nxt;
   logic [WIDTH-1:0] r_hi, w_hi_nxt;
   logic [WIDTH-1:0] r_lo, w_lo_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_done, w_done_nxt;

   logic [WIDTH-1:0] w_sum;
   logic             w_cout;

   yAdder32 u_adder (
      .a    (r_hi),
      .b    (r_m),
      .cin  (1'b0),
      .z    (w_sum),
      .cout (w_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_m     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_m     <= w_m_nxt;
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_m_nxt     = r_m;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_m_nxt     = a;
               w_hi_nxt    = '0;
               w_lo_nxt    = b;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // The 33-bit partial sum shifts right so the carry lands in HI's MSB.
            if (r_lo[0]) begin
               {w_hi_nxt, w_lo_nxt} = {w_cout, w_sum, r_lo[WIDTH-1:1]};
            end else begin
               {w_hi_nxt, w_lo_nxt} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
            end
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == c_last) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy    = (r_state == ST_RUN);
   assign done    = r_done;
   assign prod_hi = r_hi;
   assign prod_lo = r_lo;

endmodule : seq_mult_ctrl
`default_nettype wire

// File: tb/tb_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_ctrl
// Purpose  : Scoreboard bench for the sequential shift-add multiplier.
// Revision : 1.0
// ============================================================================
module tb_seq_mult_ctrl;

   localparam int c_iter = 32;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] prod_hi;
   logic [31:0] prod_lo;

   typedef struct {
      logic [63:0] prod;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   bad    = 0;
   int   cyc    = 0;
   int   n_done = 0;
   int   n_exp  = 0;
   logic r_prev_done = 1'b0;

   seq_mult_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .prod_hi (prod_hi),
      .prod_lo (prod_lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            n_done++;
            check("done_one_cycle", 64'(r_prev_done), 64'd0);
            check("busy_in_done", 64'(busy), 64'd0);
            if (sb.size() == 0) begin
               check("spurious_done", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("product", {prod_hi, prod_lo}, e.prod);
               // done cycle follows edge k+32 where k is the accepting edge
               check("latency", 64'(cyc - e.acc), 64'(c_iter));
            end
         end
      end
      r_prev_done = done;
   end

   // Caller must be at a negedge; returns one time unit after the accepting edge.
   task automatic issue(input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      start = 1'b1;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      e.prod = 64'(x) * 64'(y);
      e.acc  = cyc;
      sb.push_back(e);
      n_exp++;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   // Leaves the caller at the negedge of the done cycle.
   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   initial begin
      int busy_cnt;
      int done_early;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_prod", {prod_hi, prod_lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // basic 3x5 with busy window measurement
      @(negedge clk);
      issue(32'd3, 32'd5);
      busy_cnt   = 0;
      done_early = 0;
      for (int i = 0; i < c_iter; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) done_early++;
      end
      check("busy_cycles", 64'(busy_cnt), 64'(c_iter));
      check("no_early_done", 64'(done_early), 64'd0);
      wait_done("basic");
      check("basic_prod", {prod_hi, prod_lo}, 64'd15);

      // carry into HI
      @(negedge clk);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("carry");
      check("carry_hi", 64'(prod_hi), 64'hFFFF_FFFE);
      check("carry_lo", 64'(prod_lo), 64'h0000_0001);

      // start while busy is ignored
      @(negedge clk);
      issue(32'h0001_0000, 32'h0001_0000);
      repeat (9) @(negedge clk);
      start = 1'b1;
      a     = 32'd7;
      b     = 32'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start");
      check("busy_start_prod", {prod_hi, prod_lo}, 64'h1_0000_0000);
      repeat (40) @(negedge clk);
      check("busy_start_idle", 64'(busy), 64'd0);

      // back-to-back: second start lands in the done cycle
      issue(32'd2, 32'd2);
      wait_done("b2b_first");
      check("b2b_first_lo", 64'(prod_lo), 64'd4);
      issue(32'd0, 32'h1234_5678);
      check("b2b_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("b2b_done_low", 64'(done), 64'd0);
      wait_done("b2b_second");
      check("b2b_second_prod", {prod_hi, prod_lo}, 64'd0);

      // reset mid-run
      @(negedge clk);
      issue(32'hDEAD_BEEF, 32'h1357_9BDF);
      repeat (14) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      n_exp--;
      @(posedge clk);
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_prod", {prod_hi, prod_lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      issue(32'd6, 32'd7);
      wait_done("after_rst");
      check("after_rst_lo", 64'(prod_lo), 64'd42);

      // random sweep, back-to-back issue in each done cycle
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
         logic [31:0] x;
         logic [31:0] y;
         case (i % 8)
            0:       begin x = 32'hFFFF_FFFF; y = $urandom; end
            1:       begin x = $urandom;      y = 32'd0;    end
            default: begin x = $urandom;      y = $urandom; end
         endcase
         issue(x, y);
         wait_done("sweep");
      end

      repeat (5) @(negedge clk);
      check("done_count", 64'(n_done), 64'(n_exp));
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_seq_mult_ctrl
`default_nettype wire
